// File: rtl/muldiv_pkg.sv
// Shared encodings and latency helper for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } muldiv_state_e;

    // Edges from the accepting edge to the result-writing edge.
    function automatic int MULDIV_LAT(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference when it does not borrow.
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    // The incoming remainder is always below the divisor, so the difference fits WIDTH bits.
    assign shifted   = {rem_i, quot_i[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, div_i});
    assign diff      = shifted[WIDTH-1:0] - div_i;

    assign rem_o  = no_borrow ? diff : shifted[WIDTH-1:0];
    assign quot_o = {quot_i[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU (radix-2 Booth) and DIV/DIVU (restoring) unit with a fixed latency.
// Divide datapath is compiled in only when MULDIV_DIV_EN is defined; otherwise divides report err.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int                LAT      = MULDIV_LAT(WIDTH);
    localparam int                CNT_W    = $clog2(LAT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAT - 1);

    muldiv_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   q_q, q_d;
    logic [WIDTH:0]   m_q, m_d;
    logic             qm1_q, qm1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             err_pend_q, err_pend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;

`ifdef MULDIV_DIV_EN
    localparam logic [CNT_W-1:0] CNT_FIX = CNT_W'(WIDTH);

    logic             is_div_q, is_div_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign a_neg = ~op[0] & in_A[WIDTH-1];
    assign b_neg = ~op[0] & in_B[WIDTH-1];
    assign abs_a = a_neg ? -in_A : in_A;
    assign abs_b = b_neg ? -in_B : in_B;

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i  (acc_q[WIDTH-1:0]),
        .quot_i (q_q[WIDTH-1:0]),
        .div_i  (m_q[WIDTH-1:0]),
        .rem_o  (step_rem),
        .quot_o (step_quo)
    );
`endif

    // Low 2*WIDTH bits of the (2*WIDTH+2)-bit Booth product held in {acc, q}.
    assign mult_hi = {acc_q[WIDTH-2:0], q_q[WIDTH]};
    assign mult_lo = q_q[WIDTH-1:0];

    always_comb begin
        booth_sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b10:   booth_sum = acc_q - m_q;
            2'b01:   booth_sum = acc_q + m_q;
            default: booth_sum = acc_q;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        q_d        = q_q;
        m_d        = m_q;
        qm1_d      = qm1_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_pend_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d   = is_div_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
`endif

        // A rejected divide reports one edge after acceptance without entering RUN.
        if (err_pend_q) begin
            done_d = 1'b1;
            err_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef MULDIV_DIV_EN
                    if (op[1] && (in_B == '0)) begin
                        err_pend_d = 1'b1;
                    end else if (op[1]) begin
                        state_d   = ST_RUN;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        acc_d     = '0;
                        q_d       = {1'b0, abs_a};
                        m_d       = {1'b0, abs_b};
                        qm1_d     = 1'b0;
                        is_div_d  = 1'b1;
                        quo_neg_d = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                    end else begin
                        state_d  = ST_RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        acc_d    = '0;
                        q_d      = op[0] ? {1'b0, in_A} : {in_A[WIDTH-1], in_A};
                        m_d      = op[0] ? {1'b0, in_B} : {in_B[WIDTH-1], in_B};
                        qm1_d    = 1'b0;
                        is_div_d = 1'b0;
                    end
`else
                    if (op[1]) begin
                        err_pend_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        acc_d   = '0;
                        q_d     = op[0] ? {1'b0, in_A} : {in_A[WIDTH-1], in_A};
                        m_d     = op[0] ? {1'b0, in_B} : {in_B[WIDTH-1], in_B};
                        qm1_d   = 1'b0;
                    end
`endif
                end
            end

            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
`ifdef MULDIV_DIV_EN
                    hi_d    = is_div_q ? acc_q[WIDTH-1:0] : mult_hi;
                    lo_d    = is_div_q ? q_q[WIDTH-1:0]   : mult_lo;
`else
                    hi_d    = mult_hi;
                    lo_d    = mult_lo;
`endif
`ifdef MULDIV_DIV_EN
                end else if (is_div_q) begin
                    if (cnt_q == CNT_FIX) begin
                        q_d   = {1'b0, (quo_neg_q ? -q_q[WIDTH-1:0]   : q_q[WIDTH-1:0])};
                        acc_d = {1'b0, (rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0])};
                    end else begin
                        acc_d = {1'b0, step_rem};
                        q_d   = {1'b0, step_quo};
                    end
`endif
                end else begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_d   = {booth_sum[0], q_q[WIDTH:1]};
                    qm1_d = q_q[0];
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: every flop, working registers included, is cleared by reset so an aborted run leaves nothing behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            m_q        <= '0;
            qm1_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            m_q        <= m_d;
            qm1_q      <= qm1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q   <= is_div_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
